// File: rtl/hbus_txn_sequencer.sv
// hbus_txn_sequencer
//   Runs one HyperBus transaction per accepted request. It lowers CS#, shifts
//   out the 48-bit CA word MSB byte first, waits the initial latency (single
//   or doubled, depending on RWDS during the first CA byte), and then moves a
//   fixed burst of bytes. One byte moves per clk; the PHY does the DDR
//   conversion.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_ca[47:0]          CA word, bit 47 = 1 for a read
//   wr_data/wr_pop        first-word-fall-through write byte source
//   rd_data/rd_valid      captured read byte, one rd_valid pulse per byte
//   done/error            end-of-transaction pulse; error = read timed out
//   cs_n, ck_en           chip select and PHY clock enable
//   dq_out/dq_oe/dq_in    DQ byte lane toward/from the PHY
//   rwds_in/out/oe        RWDS; rwds_out is always 0 (no write masking)
module hbus_txn_sequencer #(
    parameter int LATENCY     = 6,
    parameter int BURST_LEN   = 32,
    parameter int CSHI_CYCLES = 2,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [47:0] req_ca,
    input  logic [7:0]  wr_data,
    output logic        wr_pop,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        error,
    output logic        cs_n,
    output logic        ck_en,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    input  logic [7:0]  dq_in,
    input  logic        rwds_in,
    output logic        rwds_out,
    output logic        rwds_oe
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // cs_n is high in CSHI and in the IDLE cycle in which the next request is
    // accepted, so CSHI itself lasts one cycle less than the minimum gap.
    localparam int CSHI_LEN = (CSHI_CYCLES > 1) ? CSHI_CYCLES - 1 : 1;
    localparam int CNT_MAX  = max2(max2(6, 2 * LATENCY),
                                   max2(max2(BURST_LEN, RD_TIMEOUT), CSHI_LEN));
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int RW       = $clog2(BURST_LEN + 1);

    localparam logic [CW-1:0] CA_LAST    = CW'(5);
    localparam logic [CW-1:0] LAT1_LAST  = CW'(LATENCY - 1);
    localparam logic [CW-1:0] LAT2_LAST  = CW'(2 * LATENCY - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(RD_TIMEOUT - 1);
    localparam logic [CW-1:0] CSHI_LAST  = CW'(CSHI_LEN - 1);
    localparam logic [RW-1:0] RD_LAST    = RW'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, CA, LAT, DATA, CSHI} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [RW-1:0] rd_cnt;
    logic [47:0]   ca_reg, ca_next;
    logic          is_read, dbl_lat;
    logic          accept, capture, timeout;
    logic [CW-1:0] lat_last;

    logic       cs_n_d, ck_en_d, req_ready_d, dq_oe_d, wr_pop_d, rwds_oe_d;
    logic       rd_valid_d, done_d, error_d;
    logic [7:0] dq_out_d, rd_data_d;

    assign lat_last = dbl_lat ? LAT2_LAST : LAT1_LAST;
    assign ca_next  = accept ? req_ca : ca_reg;
    assign rwds_out = 1'b0;

    // State register plus per-transaction context (CA word, direction,
    // latency mode and received byte count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_cnt  <= '0;
            ca_reg  <= '0;
            is_read <= 1'b0;
            dbl_lat <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                ca_reg  <= req_ca;
                is_read <= req_ca[47];
                rd_cnt  <= '0;
            end
            if (state == CA && cnt == '0) begin
                dbl_lat <= rwds_in;
            end
            if (capture) begin
                rd_cnt <= rd_cnt + RW'(1);
            end
        end
    end

    // Next-state logic; cnt counts cycles spent in the current state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = CA;
                end
            end
            CA: begin
                if (cnt == CA_LAST) begin
                    state_next = LAT;
                    cnt_next   = '0;
                end
            end
            LAT: begin
                if (cnt == lat_last) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                if (is_read) begin
                    capture = rwds_in;
                    // A final byte arriving in the last allowed cycle wins.
                    if (capture && rd_cnt == RD_LAST) begin
                        state_next = CSHI;
                        cnt_next   = '0;
                    end else if (cnt == TO_LAST) begin
                        state_next = CSHI;
                        cnt_next   = '0;
                        timeout    = 1'b1;
                    end
                end else if (cnt == BURST_LAST) begin
                    state_next = CSHI;
                    cnt_next   = '0;
                end
            end
            CSHI: begin
                if (cnt == CSHI_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the state being
    // entered. wr_pop is raised one cycle ahead of each write DATA cycle so
    // the popped byte lands in the dq_out register for that cycle.
    always_comb begin
        cs_n_d      = 1'b1;
        ck_en_d     = 1'b0;
        req_ready_d = 1'b0;
        dq_oe_d     = 1'b0;
        dq_out_d    = '0;
        wr_pop_d    = 1'b0;
        rwds_oe_d   = 1'b0;
        rd_valid_d  = capture;
        rd_data_d   = capture ? dq_in : rd_data;
        done_d      = (state == DATA) && (state_next == CSHI);
        error_d     = timeout;
        case (state_next)
            IDLE: req_ready_d = 1'b1;
            CA: begin
                cs_n_d  = 1'b0;
                ck_en_d = 1'b1;
                dq_oe_d = 1'b1;
                case (cnt_next[2:0])
                    3'd0:    dq_out_d = ca_next[47:40];
                    3'd1:    dq_out_d = ca_next[39:32];
                    3'd2:    dq_out_d = ca_next[31:24];
                    3'd3:    dq_out_d = ca_next[23:16];
                    3'd4:    dq_out_d = ca_next[15:8];
                    default: dq_out_d = ca_next[7:0];
                endcase
            end
            LAT: begin
                cs_n_d   = 1'b0;
                ck_en_d  = 1'b1;
                wr_pop_d = !is_read && (cnt_next == lat_last);
            end
            DATA: begin
                cs_n_d  = 1'b0;
                ck_en_d = 1'b1;
                if (!is_read) begin
                    dq_oe_d   = 1'b1;
                    rwds_oe_d = 1'b1;
                    dq_out_d  = wr_data;
                    wr_pop_d  = (cnt_next != BURST_LAST);
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n      <= 1'b1;
            req_ready <= 1'b1;
            ck_en     <= 1'b0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            wr_pop    <= 1'b0;
            rwds_oe   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            cs_n      <= cs_n_d;
            req_ready <= req_ready_d;
            ck_en     <= ck_en_d;
            dq_oe     <= dq_oe_d;
            dq_out    <= dq_out_d;
            wr_pop    <= wr_pop_d;
            rwds_oe   <= rwds_oe_d;
            rd_valid  <= rd_valid_d;
            rd_data   <= rd_data_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_hbus_txn_sequencer.sv
// tb_hbus_txn_sequencer
//   Self-checking bench for hbus_txn_sequencer: a table of directed
//   transactions, hand-written back-to-back and mid-transaction reset
//   sequences, and randomized transactions scored by a transaction-level model.
module tb_hbus_txn_sequencer;

    localparam int LATENCY     = 6;
    localparam int BURST_LEN   = 32;
    localparam int CSHI_CYCLES = 2;
    localparam int RD_TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [47:0] req_ca = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_pop;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        error;
    logic        cs_n;
    logic        ck_en;
    logic [7:0]  dq_out;
    logic        dq_oe;
    logic [7:0]  dq_in = '0;
    logic        rwds_in = 1'b0;
    logic        rwds_out;
    logic        rwds_oe;

    int    passCnt = 0;
    int    totalCnt = 0;
    string curTag = "init";

    typedef struct {
        bit          isRead;
        logic [47:0] ca;
        bit          dbl;
        int          nStrobes;
        int          expLat;
        int          expDataLen;
        bit          expErr;
    } vec_t;

    always #5 clk = ~clk;

    hbus_txn_sequencer #(
        .LATENCY(LATENCY), .BURST_LEN(BURST_LEN),
        .CSHI_CYCLES(CSHI_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ca(req_ca), .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .error(error), .cs_n(cs_n),
        .ck_en(ck_en), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
        .rwds_in(rwds_in), .rwds_out(rwds_out), .rwds_oe(rwds_oe)
    );

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        totalCnt++;
        if (actual == expected) passCnt++;
        else $display("[TB] FAIL %s/%s: got %0h, expected %0h", curTag, name, actual, expected);
    endtask

    // Transaction-level reference: latency from the RWDS flag, burst length
    // from where the BURST_LEN-th read strobe falls inside the timeout window.
    task automatic modelTxn(input bit isRead, input bit dbl, input bit [63:0] mask,
                            output int lat, output int dataLen, output bit err);
        int n;
        lat = dbl ? 2 * LATENCY : LATENCY;
        dataLen = BURST_LEN;
        err = 1'b0;
        if (isRead) begin
            n = 0;
            dataLen = RD_TIMEOUT;
            err = 1'b1;
            for (int j = 0; j < RD_TIMEOUT; j++) begin
                if (mask[j]) n++;
                if (n == BURST_LEN) begin
                    dataLen = j + 1;
                    err = 1'b0;
                    break;
                end
            end
        end
    endtask

    // Drives one transaction starting from an IDLE DUT just after a negedge,
    // observes every cycle at the negedge and compares the aggregate result.
    task automatic applyStimulus(input bit isRead, input logic [47:0] ca, input bit dbl,
                                 input bit [63:0] mask, input bit holdValid,
                                 input int expLat, input int expDataLen, input bit expErr);
        logic [7:0]  src[$];
        logic [7:0]  expWr[$];
        logic [7:0]  expRd[$];
        logic [7:0]  caObs[$];
        logic [7:0]  datObs[$];
        logic [7:0]  rdObs[$];
        logic [47:0] caWord;
        int lowCnt = 0, oeCnt = 0, popCnt = 0, firstPop = -1, firstDat = -1;
        int firstRd = -1, doneCnt = 0, doneIdx = -1, tailHigh = 0, rwdsBad = 0, ckBad = 0;
        int bad, c, j, d0;
        bit errObs = 1'b0, popPending = 1'b0, finished = 1'b0;

        d0 = 6 + expLat;
        for (int i = 0; i < BURST_LEN + 8; i++) src.push_back(8'($urandom));
        expWr = src;
        wr_data = src[0];
        req_valid = 1'b1;
        req_ca = ca;
        rwds_in = 1'($urandom);
        @(posedge clk);
        c = 0;
        while (!finished && c < 300) begin
            #1;
            if (popPending) begin
                void'(src.pop_front());
                wr_data = (src.size() > 0) ? src[0] : 8'h00;
                popPending = 1'b0;
            end
            @(negedge clk);
            if (!cs_n) lowCnt++;
            if (cs_n == ck_en) ckBad++;
            if (dq_oe) oeCnt++;
            if (!cs_n && dq_oe && !rwds_oe) caObs.push_back(dq_out);
            if (dq_oe && rwds_oe) begin
                if (firstDat < 0) firstDat = c;
                datObs.push_back(dq_out);
            end
            if (rwds_oe && rwds_out) rwdsBad++;
            if (wr_pop) begin
                popCnt++;
                if (firstPop < 0) firstPop = c;
                popPending = 1'b1;
            end
            if (rd_valid) begin
                if (firstRd < 0) firstRd = c;
                rdObs.push_back(rd_data);
            end
            if (done) begin
                doneCnt++;
                doneIdx = c;
                errObs = error;
            end
            if (doneCnt > 0 && cs_n) tailHigh++;
            if (doneCnt > 0 && req_ready) finished = 1'b1;
            if (!finished) begin
                req_valid = holdValid;
                req_ca = 48'({$urandom(), $urandom()});
                dq_in = 8'($urandom);
                j = c - d0;
                if (c == 0) rwds_in = dbl;
                else if (isRead && j >= 0 && j < expDataLen) begin
                    rwds_in = mask[j];
                    if (mask[j]) expRd.push_back(dq_in);
                end else rwds_in = 1'($urandom);
                @(posedge clk);
                c++;
            end
        end

        checkOutput("finished", finished, 1);
        caWord = '0;
        foreach (caObs[i]) caWord = {caWord[39:0], caObs[i]};
        checkOutput("ca_count", caObs.size(), 6);
        checkOutput("ca_bytes", caWord, ca);
        checkOutput("cs_low_cycles", lowCnt, d0 + expDataLen);
        checkOutput("ck_en_follows_cs", ckBad, 0);
        checkOutput("done_count", doneCnt, 1);
        checkOutput("done_cycle", doneIdx, d0 + expDataLen);
        checkOutput("error", errObs, expErr);
        checkOutput("cs_high_gap", tailHigh, CSHI_CYCLES);
        if (!isRead) begin
            checkOutput("wr_pop_count", popCnt, BURST_LEN);
            checkOutput("first_pop_cycle", firstPop, d0 - 1);
            checkOutput("first_wr_byte_cycle", firstDat, d0);
            checkOutput("dq_oe_cycles", oeCnt, 6 + BURST_LEN);
            checkOutput("rwds_out_zero", rwdsBad, 0);
            checkOutput("wr_byte_count", datObs.size(), BURST_LEN);
            bad = 0;
            foreach (datObs[i]) if (i < BURST_LEN && datObs[i] != expWr[i]) bad++;
            checkOutput("wr_byte_order", bad, 0);
        end else begin
            checkOutput("rd_pop_none", popCnt, 0);
            checkOutput("dq_oe_cycles", oeCnt, 6);
            checkOutput("first_rd_cycle", firstRd, d0 + 1);
            checkOutput("rd_byte_count", rdObs.size(), expRd.size());
            bad = 0;
            foreach (rdObs[i]) if (i < expRd.size() && rdObs[i] != expRd[i]) bad++;
            checkOutput("rd_byte_order", bad, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[5];
        bit [63:0]  mask;
        int         lat, dataLen, doneSeen;
        bit         err, isRead, dbl;
        logic [47:0] ca;

        vecs[0] = '{1'b0, 48'h0000_0002_0000, 1'b0,  0,  6, 32, 1'b0};
        vecs[1] = '{1'b1, 48'h8000_0001_0040, 1'b0, 64,  6, 32, 1'b0};
        vecs[2] = '{1'b1, 48'h8000_0003_0000, 1'b1, 64, 12, 32, 1'b0};
        vecs[3] = '{1'b1, 48'h8000_0000_0100, 1'b0, 20,  6, 64, 1'b1};
        vecs[4] = '{1'b0, 48'h0012_3456_789A, 1'b1,  0, 12, 32, 1'b0};

        $display("[TB] reset state");
        #12;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_cs_n", cs_n, 1);
        checkOutput("rst_ck_en", ck_en, 0);
        checkOutput("rst_dq_oe", dq_oe, 0);
        checkOutput("rst_wr_pop", wr_pop, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_rwds_oe", rwds_oe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            curTag = $sformatf("vec%0d", i);
            mask = (vecs[i].nStrobes >= 64) ? '1 : ((64'd1 << vecs[i].nStrobes) - 64'd1);
            applyStimulus(vecs[i].isRead, vecs[i].ca, vecs[i].dbl, mask, 1'b0,
                          vecs[i].expLat, vecs[i].expDataLen, vecs[i].expErr);
        end

        $display("[TB] back-to-back writes with req_valid held");
        curTag = "b2b_first";
        applyStimulus(1'b0, 48'h0000_00AB_CD00, 1'b0, '0, 1'b1, LATENCY, BURST_LEN, 1'b0);
        curTag = "b2b_second";
        applyStimulus(1'b0, 48'h0000_0011_2200, 1'b0, '0, 1'b0, LATENCY, BURST_LEN, 1'b0);

        $display("[TB] reset during write DATA");
        curTag = "mid_reset";
        req_valid = 1'b1;
        req_ca = 48'h0000_0000_0800;
        rwds_in = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("cs_n_now_high", cs_n, 1);
        checkOutput("dq_oe_now_low", dq_oe, 0);
        checkOutput("wr_pop_now_low", wr_pop, 0);
        checkOutput("req_ready_now_high", req_ready, 1);
        doneSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("no_done_after_abort", doneSeen, 0);
        curTag = "after_reset";
        applyStimulus(1'b0, 48'h0000_0005_0000, 1'b0, '0, 1'b0, LATENCY, BURST_LEN, 1'b0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 16; t++) begin
            int density;
            curTag = $sformatf("rand%0d", t);
            isRead = 1'($urandom);
            dbl = 1'($urandom);
            ca = 48'({$urandom(), $urandom()});
            ca[47] = isRead;
            density = $urandom_range(30, 100);
            mask = '0;
            for (int j = 0; j < 64; j++) mask[j] = ($urandom_range(0, 99) < density);
            mask[0] = 1'b1;
            modelTxn(isRead, dbl, mask, lat, dataLen, err);
            applyStimulus(isRead, ca, dbl, mask, 1'b0, lat, dataLen, err);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
